// File: rtl/bip_pkg.sv
// Shared widths and record layout for the BIP CPU trace path.
// A trace record is packed as {PC, ACC} with ACC in the low bits.
package bip_pkg;

    localparam int unsigned BIP_DATA_W  = 16;
    localparam int unsigned BIP_ADDR_W  = 11;
    localparam int unsigned BIP_REC_W   = BIP_ADDR_W + BIP_DATA_W;
    localparam int unsigned BIP_ACC_LSB = 0;
    localparam int unsigned BIP_PC_LSB  = BIP_DATA_W;
    localparam int unsigned BIP_DROP_W  = 16;

    function automatic int unsigned bip_rec_w(input int unsigned addr_w,
                                              input int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/bip_trace_ram.sv
// Trace record storage: synchronous write, asynchronous read, no reset.
module bip_trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 27
) (
    input  logic                     CLK,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bip_acc_trace_fifo.sv
// Accumulator-write trace FIFO for the BIP CPU: captures {PC, ACC} on WR_ACC
// one cycle late (ACC settles after the write) and drains via FWFT valid/ready.
module bip_acc_trace_fifo
    import bip_pkg::*;
#(
    parameter int unsigned DATA_W    = BIP_DATA_W,
    parameter int unsigned ADDR_W    = BIP_ADDR_W,
    parameter int unsigned DEPTH     = 16,
    parameter bit          OVERWRITE = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic                     CLEAR,
    input  logic                     WR_ACC,
    input  logic [DATA_W-1:0]        ACC_IN,
    input  logic [ADDR_W-1:0]        PC_IN,
    input  logic                     RD_READY,
    output logic                     RD_VALID,
    output logic [DATA_W-1:0]        RD_ACC,
    output logic [ADDR_W-1:0]        RD_PC,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVERFLOW,
    output logic [BIP_DROP_W-1:0]    DROP_COUNT
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = bip_rec_w(ADDR_W, DATA_W);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bip_acc_trace_fifo: DEPTH must be a power of two >= 2");
    end

    logic                  r_pend;
    logic [ADDR_W-1:0]     r_pc_lat;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [BIP_DROP_W-1:0] r_drop_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_wr_en;
    logic                  w_rd_adv;
    logic [REC_W-1:0]      w_wr_data;
    logic [REC_W-1:0]      w_rd_data;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push    = r_pend;
    assign w_pop     = !w_empty && RD_READY;
    // A full FIFO with a simultaneous pop has a free slot by the edge, so only
    // an unmatched push into a full FIFO loses a record.
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_wr_en   = w_push && (!w_drop || OVERWRITE) && !CLEAR;
    assign w_rd_adv  = w_pop || (w_drop && OVERWRITE);
    assign w_wr_data = {r_pc_lat, ACC_IN};

    bip_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pend       <= 1'b0;
            r_pc_lat     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (CLEAR) begin
            r_pend       <= 1'b0;
            r_pc_lat     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_pend <= ENABLE && WR_ACC;
            if (ENABLE && WR_ACC)
                r_pc_lat <= PC_IN;

            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            if (w_push && !w_pop && !w_full)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1)
                    r_drop_count <= r_drop_count + BIP_DROP_W'(1);
            end
        end
    end

    assign RD_VALID   = !w_empty;
    assign RD_ACC     = w_empty ? '0 : w_rd_data[BIP_ACC_LSB +: DATA_W];
    assign RD_PC      = w_empty ? '0 : w_rd_data[DATA_W +: ADDR_W];
    assign COUNT      = r_count;
    assign FULL       = w_full;
    assign EMPTY      = w_empty;
    assign OVERFLOW   = r_overflow;
    assign DROP_COUNT = r_drop_count;

endmodule

// File: tb/tb_bip_acc_trace_fifo.sv
// Bench for bip_acc_trace_fifo: a drop-mode and an overwrite-mode instance share
// stimulus and are compared against queue-based reference models.
module tb_bip_acc_trace_fifo;

    localparam int DW    = 16;
    localparam int AW    = 11;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int VW    = CW + 3 + AW + DW + 1 + 16;

    typedef logic [AW+DW-1:0] rec_t;

    logic          CLK = 1'b0;
    logic          RESET, ENABLE, CLEAR, WR_ACC, RD_READY;
    logic [DW-1:0] ACC_IN;
    logic [AW-1:0] PC_IN;

    logic          d0_valid, d0_full, d0_empty, d0_ovf;
    logic [DW-1:0] d0_acc;
    logic [AW-1:0] d0_pc;
    logic [CW-1:0] d0_count;
    logic [15:0]   d0_drop;
    logic          d1_valid, d1_full, d1_empty, d1_ovf;
    logic [DW-1:0] d1_acc;
    logic [AW-1:0] d1_pc;
    logic [CW-1:0] d1_count;
    logic [15:0]   d1_drop;

    logic [VW-1:0] obs0, obs1;
    assign obs0 = {d0_count, d0_full, d0_empty, d0_valid, d0_pc, d0_acc, d0_ovf, d0_drop};
    assign obs1 = {d1_count, d1_full, d1_empty, d1_valid, d1_pc, d1_acc, d1_ovf, d1_drop};

    always #5 CLK = ~CLK;

    bip_acc_trace_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OVERWRITE(1'b0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .WR_ACC(WR_ACC),
        .ACC_IN(ACC_IN), .PC_IN(PC_IN), .RD_READY(RD_READY), .RD_VALID(d0_valid),
        .RD_ACC(d0_acc), .RD_PC(d0_pc), .COUNT(d0_count), .FULL(d0_full),
        .EMPTY(d0_empty), .OVERFLOW(d0_ovf), .DROP_COUNT(d0_drop));

    bip_acc_trace_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .OVERWRITE(1'b1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .WR_ACC(WR_ACC),
        .ACC_IN(ACC_IN), .PC_IN(PC_IN), .RD_READY(RD_READY), .RD_VALID(d1_valid),
        .RD_ACC(d1_acc), .RD_PC(d1_pc), .COUNT(d1_count), .FULL(d1_full),
        .EMPTY(d1_empty), .OVERFLOW(d1_ovf), .DROP_COUNT(d1_drop));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: a record is the PC seen at the WR_ACC edge paired with
    // the ACC value present on the following edge.
    rec_t        q0[$];
    rec_t        q1[$];
    int unsigned dr0, dr1;
    bit          ov0, ov1;
    bit          m_pend;
    logic [AW-1:0] m_pc;

    task automatic fifo_step(input bit ow, input bit push, input rec_t rec, input bit rdy,
                             inout rec_t q[$], inout int unsigned drops, inout bit ovf);
        if (q.size() > 0 && rdy)
            void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) begin
                q.push_back(rec);
            end else begin
                if (drops < 65535) drops++;
                ovf = 1'b1;
                if (ow) begin
                    void'(q.pop_front());
                    q.push_back(rec);
                end
            end
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        dr0 = 0; dr1 = 0; ov0 = 0; ov1 = 0; m_pend = 0; m_pc = '0;
    endtask

    task automatic model_step();
        if (CLEAR) begin
            model_reset();
        end else begin
            fifo_step(1'b0, m_pend, {m_pc, ACC_IN}, RD_READY, q0, dr0, ov0);
            fifo_step(1'b1, m_pend, {m_pc, ACC_IN}, RD_READY, q1, dr1, ov1);
            m_pend = ENABLE && WR_ACC;
            if (ENABLE && WR_ACC) m_pc = PC_IN;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input rec_t q[$], input int unsigned drops, input bit ovf);
        rec_t        h;
        logic [15:0] d;
        h = (q.size() > 0) ? q[0] : '0;
        d = drops[15:0];
        return {CW'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() != 0,
                h[AW+DW-1:DW], h[DW-1:0], ovf, d};
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        ENABLE = 1'b1; CLEAR = 1'b0; WR_ACC = 1'b0; RD_READY = 1'b0;
        ACC_IN = '0; PC_IN = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        model_reset();
        #100;
        n_checks++; if (d0_empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", d0_empty); else n_pass++;
        n_checks++; if (d0_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", d0_count); else n_pass++;
        n_checks++; if (d0_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", d0_valid); else n_pass++;
        n_checks++; if (d0_drop !== 16'd0) $display("FAIL reset_drop: got %0d expected 0", d0_drop); else n_pass++;
        n_checks++; if (obs1 !== exp_vec(q1, dr1, ov1)) $display("FAIL reset_state1: got %h expected %h", obs1, exp_vec(q1, dr1, ov1)); else n_pass++;
        RESET = 1'b0;
    endtask

    task automatic test_single();
        WR_ACC = 1'b1; PC_IN = 11'h005; ACC_IN = 16'h0000;
        cycle();
        WR_ACC = 1'b0; ACC_IN = 16'h0007;
        n_checks++; if (d0_valid !== 1'b0) $display("FAIL single_latency: got valid %b expected 0", d0_valid); else n_pass++;
        cycle();
        n_checks++; if (d0_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", d0_valid); else n_pass++;
        n_checks++; if (d0_pc !== 11'h005) $display("FAIL single_pc: got %h expected 005", d0_pc); else n_pass++;
        n_checks++; if (d0_acc !== 16'h0007) $display("FAIL single_acc: got %h expected 0007", d0_acc); else n_pass++;
        n_checks++; if (obs1 !== exp_vec(q1, dr1, ov1)) $display("FAIL single_state1: got %h expected %h", obs1, exp_vec(q1, dr1, ov1)); else n_pass++;
        RD_READY = 1'b1;
        cycle();
        RD_READY = 1'b0;
        n_checks++; if (d0_empty !== 1'b1) $display("FAIL single_drain: got empty %b expected 1", d0_empty); else n_pass++;
    endtask

    task automatic test_burst();
        for (int i = 1; i <= 20; i++) begin
            WR_ACC = 1'b1; PC_IN = AW'(11'h100 + i); ACC_IN = DW'(16'h1000 + i - 1);
            cycle();
        end
        WR_ACC = 1'b0; ACC_IN = 16'h1014;
        cycle();
        n_checks++; if (d0_count !== 5'd16) $display("FAIL burst_count0: got %0d expected 16", d0_count); else n_pass++;
        n_checks++; if (d0_full !== 1'b1) $display("FAIL burst_full0: got %b expected 1", d0_full); else n_pass++;
        n_checks++; if (d0_drop !== 16'd4) $display("FAIL burst_drop0: got %0d expected 4", d0_drop); else n_pass++;
        n_checks++; if ({d0_pc, d0_acc} !== {11'h101, 16'h1001}) $display("FAIL burst_head0: got %h/%h expected 101/1001", d0_pc, d0_acc); else n_pass++;
        n_checks++; if (d1_count !== 5'd16) $display("FAIL burst_count1: got %0d expected 16", d1_count); else n_pass++;
        n_checks++; if (d1_drop !== 16'd4) $display("FAIL burst_drop1: got %0d expected 4", d1_drop); else n_pass++;
        n_checks++; if ({d1_pc, d1_acc} !== {11'h105, 16'h1005}) $display("FAIL burst_head1: got %h/%h expected 105/1005", d1_pc, d1_acc); else n_pass++;
        RD_READY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({d0_pc, d0_acc} !== {AW'(11'h101 + k), DW'(16'h1001 + k)})
                $display("FAIL burst_drain0[%0d]: got %h/%h expected %h/%h", k, d0_pc, d0_acc, 11'h101 + k, 16'h1001 + k);
            else n_pass++;
            n_checks++;
            if ({d1_pc, d1_acc} !== {AW'(11'h105 + k), DW'(16'h1005 + k)})
                $display("FAIL burst_drain1[%0d]: got %h/%h expected %h/%h", k, d1_pc, d1_acc, 11'h105 + k, 16'h1005 + k);
            else n_pass++;
            cycle();
        end
        RD_READY = 1'b0;
        n_checks++; if ({d0_empty, d1_empty} !== 2'b11) $display("FAIL burst_empty: got %b expected 11", {d0_empty, d1_empty}); else n_pass++;
    endtask

    task automatic test_full_pushpop();
        logic [15:0] drop0_before, drop1_before;
        for (int i = 0; i < 17; i++) begin
            WR_ACC = 1'b1; PC_IN = AW'($urandom); ACC_IN = DW'($urandom);
            cycle();
        end
        drop0_before = dr0[15:0];
        drop1_before = dr1[15:0];
        RD_READY = 1'b1;
        for (int i = 0; i < 24; i++) begin
            PC_IN = AW'($urandom); ACC_IN = DW'($urandom);
            cycle();
            n_checks++; if (d0_count !== 5'd16 || d1_count !== 5'd16) $display("FAIL pushpop_count[%0d]: got %0d/%0d expected 16", i, d0_count, d1_count); else n_pass++;
            n_checks++; if (d0_drop !== drop0_before || d1_drop !== drop1_before) $display("FAIL pushpop_drop[%0d]: got %0d/%0d expected %0d/%0d", i, d0_drop, d1_drop, drop0_before, drop1_before); else n_pass++;
            n_checks++; if (obs0 !== exp_vec(q0, dr0, ov0)) $display("FAIL pushpop_state0[%0d]: got %h expected %h", i, obs0, exp_vec(q0, dr0, ov0)); else n_pass++;
            n_checks++; if (obs1 !== exp_vec(q1, dr1, ov1)) $display("FAIL pushpop_state1[%0d]: got %h expected %h", i, obs1, exp_vec(q1, dr1, ov1)); else n_pass++;
        end
        WR_ACC = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ACC_IN = DW'($urandom);
            cycle();
            n_checks++; if (obs0 !== exp_vec(q0, dr0, ov0)) $display("FAIL wrapdrain_state0[%0d]: got %h expected %h", i, obs0, exp_vec(q0, dr0, ov0)); else n_pass++;
            n_checks++; if (obs1 !== exp_vec(q1, dr1, ov1)) $display("FAIL wrapdrain_state1[%0d]: got %h expected %h", i, obs1, exp_vec(q1, dr1, ov1)); else n_pass++;
        end
        RD_READY = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 18; i++) begin
            WR_ACC = 1'b1; PC_IN = AW'($urandom); ACC_IN = DW'($urandom);
            cycle();
        end
        CLEAR = 1'b1; WR_ACC = 1'b0;
        cycle();
        CLEAR = 1'b0;
        n_checks++; if (d0_count !== 5'd0 || d1_count !== 5'd0) $display("FAIL clear_count: got %0d/%0d expected 0", d0_count, d1_count); else n_pass++;
        n_checks++; if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0) $display("FAIL clear_ovf: got %b/%b expected 0", d0_ovf, d1_ovf); else n_pass++;
        n_checks++; if (d0_drop !== 16'd0 || d1_drop !== 16'd0) $display("FAIL clear_drop: got %0d/%0d expected 0", d0_drop, d1_drop); else n_pass++;
        cycle();
        n_checks++; if (d0_valid !== 1'b0 || d1_valid !== 1'b0) $display("FAIL clear_stale: got valid %b/%b expected 0", d0_valid, d1_valid); else n_pass++;
        n_checks++; if (obs0 !== exp_vec(q0, dr0, ov0)) $display("FAIL clear_state0: got %h expected %h", obs0, exp_vec(q0, dr0, ov0)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            WR_ACC = 1'b1; PC_IN = AW'($urandom); ACC_IN = DW'($urandom);
            cycle();
        end
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        n_checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) $display("FAIL rstmid_empty: got %b/%b expected 1", d0_empty, d1_empty); else n_pass++;
        n_checks++; if (d0_count !== 5'd0 || d1_count !== 5'd0) $display("FAIL rstmid_count: got %0d/%0d expected 0", d0_count, d1_count); else n_pass++;
        n_checks++; if (d0_valid !== 1'b0 || d0_drop !== 16'd0) $display("FAIL rstmid_valid_drop: got %b/%0d expected 0/0", d0_valid, d0_drop); else n_pass++;
        #1;
        RESET = 1'b0;
        idle_inputs();
        cycle();
        n_checks++; if (obs0 !== exp_vec(q0, dr0, ov0)) $display("FAIL rstmid_after: got %h expected %h", obs0, exp_vec(q0, dr0, ov0)); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ENABLE   = ($urandom_range(9) != 0);
            WR_ACC   = ($urandom_range(9) < 6);
            RD_READY = ($urandom_range(1) == 1);
            CLEAR    = ($urandom_range(39) == 0);
            PC_IN    = AW'($urandom);
            ACC_IN   = DW'($urandom);
            cycle();
            n_checks++; if (obs0 !== exp_vec(q0, dr0, ov0)) $display("FAIL random_state0[%0d]: got %h expected %h", i, obs0, exp_vec(q0, dr0, ov0)); else n_pass++;
            n_checks++; if (obs1 !== exp_vec(q1, dr1, ov1)) $display("FAIL random_state1[%0d]: got %h expected %h", i, obs1, exp_vec(q1, dr1, ov1)); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_pushpop();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
